ff_excite_driver: RTL and testbench

- Initiator side of the JK/SR flip-flop bank interface.
- Takes a requested next state for a bank of WIDTH external JK or SR flops and converts it to per-bit excitation inputs (j/k or s/r) using the excitation tables.
- Drives the excitations for one clock, reads back the flop outputs, and reports match or mismatch.
- Used as a stimulus and self-check engine in front of flop banks in the lab designs.

---
 rtl/ff_excite_if.sv | 30 +++
 rtl/ff_excite_driver.sv | 141 ++++++++++++++
 tb/tb_ff_excite_driver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ff_excite_if.sv
// Request, excitation and readback bundle between ff_excite_driver and a JK/SR flop bank.
// The master side is the driver; the slave side is the requester and flop bank environment.
interface ff_excite_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_target;
    logic             in_mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic             done;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic             busy;

    modport master (
        input  in_valid, in_target, in_mode, q_fb,
        output in_ready, j, k, s, r, done, mismatch, err_count, busy
    );

    modport slave (
        output in_valid, in_target, in_mode, q_fb,
        input  in_ready, j, k, s, r, done, mismatch, err_count, busy
    );
endinterface

// File: rtl/ff_excite_driver.sv
// Converts a requested next state into JK/SR excitations for an external flop bank, then checks readback.
// Optional macro FF_EXCITE_TOGGLE_EN: JK mode drives J=K=1 on every changing bit instead of minimal excitation.
module ff_excite_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    ff_excite_if.master  bus
);
    localparam logic [2:0] INIT     = 3'd0;
    localparam logic [2:0] INIT_CHK = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] DRIVE    = 3'd3;
    localparam logic [2:0] CHECK    = 3'd4;
    localparam logic [2:0] RESP     = 3'd5;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [2:0]       state,     state_nxt;
    logic [WIDTH-1:0] tgt,       tgt_nxt;
    logic [WIDTH-1:0] shadow,    shadow_nxt;
    logic [WIDTH-1:0] j_q,       j_nxt;
    logic [WIDTH-1:0] k_q,       k_nxt;
    logic [WIDTH-1:0] s_q,       s_nxt;
    logic [WIDTH-1:0] r_q,       r_nxt;
    logic             done_q,    done_nxt;
    logic             mis_q,     mis_nxt;
    logic [ERR_W-1:0] err_q,     err_nxt;
    logic             ready_q,   ready_nxt;
    logic             busy_q,    busy_nxt;
    logic [WIDTH-1:0] diff;

    // Next-state and next-output decode; every output register is loaded with the value for the state being entered.
    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt;
        shadow_nxt = shadow;
        j_nxt      = '0;
        k_nxt      = '0;
        s_nxt      = '0;
        r_nxt      = '0;
        done_nxt   = 1'b0;
        mis_nxt    = 1'b0;
        err_nxt    = err_q;
        diff       = shadow ^ bus.in_target;

        case (state)
            INIT: begin
                // Clear pulse lands on the bank one cycle later and is sampled at the edge leaving INIT_CHK.
                k_nxt     = '1;
                r_nxt     = '1;
                state_nxt = INIT_CHK;
            end
            INIT_CHK: begin
                state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.in_valid) begin
                    tgt_nxt   = bus.in_target;
                    state_nxt = DRIVE;
                    if (bus.in_mode) begin
                        s_nxt = diff & bus.in_target;
                        r_nxt = diff & ~bus.in_target;
                    end else begin
`ifdef FF_EXCITE_TOGGLE_EN
                        j_nxt = diff;
                        k_nxt = diff;
`else
                        j_nxt = diff & bus.in_target;
                        k_nxt = diff & ~bus.in_target;
`endif
                    end
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                // Shadow tracks the requested value so one bad flop does not poison later excitations.
                mis_nxt    = (bus.q_fb != tgt);
                done_nxt   = 1'b1;
                shadow_nxt = tgt;
                state_nxt  = RESP;
            end
            RESP: begin
                if (mis_q && (err_q != ERR_MAX)) begin
                    err_nxt = err_q + ERR_W'(1);
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            tgt     <= '0;
            shadow  <= '0;
            j_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            shadow  <= shadow_nxt;
            j_q     <= j_nxt;
            k_q     <= k_nxt;
            s_q     <= s_nxt;
            r_q     <= r_nxt;
            done_q  <= done_nxt;
            mis_q   <= mis_nxt;
            err_q   <= err_nxt;
            ready_q <= ready_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.done      = done_q;
    assign bus.mismatch  = mis_q;
    assign bus.err_count = err_q;
    assign bus.in_ready  = ready_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ff_excite_driver.sv
// Directed, table-driven bench for ff_excite_driver with an ideal JK/SR flop bank and a stuck-at fault hook.
module tb_ff_excite_driver;
    logic clk;
    logic rst;

    ff_excite_if #(.WIDTH(4), .ERR_W(8)) bus ();

    ff_excite_driver #(.WIDTH(4), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal bank: the driver keeps the unused pair at zero, so one equation covers both flop types.
    logic [3:0] bank = 4'h9;
    logic [3:0] stuck_mask = 4'h0;
    always @(posedge clk)
        bank <= bus.s | (~bus.r & ((bus.j & ~bank) | (~bus.k & bank)));
    assign bus.q_fb = bank & ~stuck_mask;

    int errors = 0;
    int checks = 0;
    int sr_viol = 0;
    int jk_viol = 0;
    int done_seen = 0;
    logic rec = 1'b0;
    logic [3:0] acc_q[$];

    always @(negedge clk) begin
        if (|(bus.s & bus.r)) sr_viol++;
`ifndef FF_EXCITE_TOGGLE_EN
        if (|(bus.j & bus.k)) jk_viol++;
`endif
        if (rec && bus.done) done_seen++;
    end

    always @(posedge clk)
        if (rec && bus.in_valid && bus.in_ready) acc_q.push_back(bus.in_target);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic exp_jk(input logic [3:0] sh, input logic [3:0] tg,
                          output logic [3:0] ej, output logic [3:0] ek);
`ifdef FF_EXCITE_TOGGLE_EN
        ej = sh ^ tg;
        ek = sh ^ tg;
`else
        ej = tg & ~sh;
        ek = sh & ~tg;
`endif
    endtask

    task automatic do_req(input logic mode, input logic [3:0] tgt,
                          input logic [3:0] ej, input logic [3:0] ek,
                          input logic [3:0] es, input logic [3:0] er,
                          input logic emis, input logic [7:0] eerr);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_target = tgt;
        bus.in_mode   = mode;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        chk("drive_j", 32'(bus.j), 32'(ej));
        chk("drive_k", 32'(bus.k), 32'(ek));
        chk("drive_s", 32'(bus.s), 32'(es));
        chk("drive_r", 32'(bus.r), 32'(er));
        chk("drive_done", 32'(bus.done), 32'd0);
        chk("drive_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk("check_exc", 32'({bus.j, bus.k, bus.s, bus.r}), 32'd0);
        chk("check_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        chk("resp_done", 32'(bus.done), 32'd1);
        chk("resp_mismatch", 32'(bus.mismatch), 32'(emis));
        @(posedge clk); #1;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_err_count", 32'(bus.err_count), 32'(eerr));
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        logic       mode;
        logic [3:0] tgt;
        logic [3:0] j, k, jt, kt, s, r;
    } vec_t;

    vec_t tbl[7];
    logic [3:0] vals[12];
    logic [3:0] ej, ek, sh;

    initial begin
        // Shadow chain: 0 -> A -> 5 -> 3 -> 3 -> C -> 0 -> 0.
        tbl[0] = '{1'b0, 4'hA, 4'hA, 4'h0, 4'hA, 4'hA, 4'h0, 4'h0};
        tbl[1] = '{1'b0, 4'h5, 4'h5, 4'hA, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[2] = '{1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4};
        tbl[3] = '{1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[4] = '{1'b0, 4'hC, 4'hC, 4'h3, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[5] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC};
        tbl[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 12; i++) vals[i] = 4'(i * 5 + 2);

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_target = 4'h0;
        bus.in_mode   = 1'b0;
        @(posedge clk); #1;
        chk("rst_exc", 32'({bus.j, bus.k, bus.s, bus.r}), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("init_k", 32'(bus.k), 32'hF);
        chk("init_r", 32'(bus.r), 32'hF);
        chk("init_js", 32'({bus.j, bus.s}), 32'd0);
        chk("init_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_ready_after_init", 32'(bus.in_ready), 32'd1);
        chk("idle_busy_after_init", 32'(bus.busy), 32'd0);
        chk("idle_exc_after_init", 32'({bus.j, bus.k, bus.s, bus.r}), 32'd0);
        chk("bank_cleared", 32'(bus.q_fb), 32'd0);

        for (int i = 0; i < 7; i++) begin
`ifdef FF_EXCITE_TOGGLE_EN
            ej = tbl[i].jt; ek = tbl[i].kt;
`else
            ej = tbl[i].j;  ek = tbl[i].k;
`endif
            do_req(tbl[i].mode, tbl[i].tgt, ej, ek, tbl[i].s, tbl[i].r, 1'b0, 8'd0);
        end

        // Bit0 stuck at 0: every request for 4'h1 mismatches and the counter saturates.
        stuck_mask = 4'h1;
        exp_jk(4'h0, 4'h1, ej, ek);
        do_req(1'b0, 4'h1, ej, ek, 4'h0, 4'h0, 1'b1, 8'd1);
        for (int i = 2; i <= 300; i++)
            do_req(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, (i > 255) ? 8'd255 : 8'(i));
        chk("err_saturated", 32'(bus.err_count), 32'd255);
        stuck_mask = 4'h0;

        // in_valid held for 12 cycles: accepts land on cycles 0, 4 and 8 only.
        wait_ready();
        sh  = 4'h1;
        rec = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_target = vals[i];
            bus.in_mode   = 1'b0;
            @(posedge clk); #1;
            if (i % 4 == 0) begin
                exp_jk(sh, vals[i], ej, ek);
                chk("stream_j", 32'(bus.j), 32'(ej));
                chk("stream_k", 32'(bus.k), 32'(ek));
                sh = vals[i];
            end
        end
        bus.in_valid = 1'b0;
        rec = 1'b0;
        chk("stream_accepts", 32'(acc_q.size()), 32'd3);
        chk("stream_done_pulses", 32'(done_seen), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("stream_value", (acc_q.size() > i) ? 32'(acc_q[i]) : 32'hDEAD, 32'(vals[i * 4]));

        // Reset landing in DRIVE aborts the request and restarts through INIT.
        wait_ready();
        done_seen = 0;
        rec = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_target = 4'h6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("abort_in_drive", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_exc", 32'({bus.j, bus.k, bus.s, bus.r}), 32'd0);
        chk("abort_err", 32'(bus.err_count), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_init_kr", 32'({bus.k, bus.r}), 32'hFF);
        @(posedge clk); #1;
        chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);
        rec = 1'b0;
        chk("abort_no_done", 32'(done_seen), 32'd0);
        exp_jk(4'h0, 4'h6, ej, ek);
        do_req(1'b0, 4'h6, ej, ek, 4'h0, 4'h0, 1'b0, 8'd0);

        chk("sr_never_both", 32'(sr_viol), 32'd0);
        chk("jk_never_both", 32'(jk_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
